// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion, hold and flush.
// Optional build macro STALL_STATS_EN adds a 32-bit counter of inserted load-use bubbles.
module id_ex_stage_reg #(
    parameter int XLEN    = 32,
    parameter int REG_AW  = 5,
    parameter int ALUOP_W = 4
) (
    input  logic               clk,
    input  logic               reset,

    input  logic               id_valid,
    input  logic [REG_AW-1:0]  id_rs1,
    input  logic [REG_AW-1:0]  id_rs2,
    input  logic               id_uses_rs2,
    input  logic [REG_AW-1:0]  id_rd,
    input  logic [XLEN-1:0]    id_rs1_data,
    input  logic [XLEN-1:0]    id_rs2_data,
    input  logic [XLEN-1:0]    id_imm,
    input  logic [XLEN-1:0]    id_pc,
    input  logic               id_alu_src,
    input  logic [ALUOP_W-1:0] id_alu_op,
    input  logic               id_mem_read,
    input  logic               id_mem_write,
    input  logic               id_reg_write,
    input  logic               id_mem_to_reg,

    input  logic               flush,
    input  logic               hold,
    output logic               stall_fd,

    output logic               ex_valid,
    output logic [REG_AW-1:0]  ex_rs1,
    output logic [REG_AW-1:0]  ex_rs2,
    output logic [REG_AW-1:0]  ex_rd,
    output logic [XLEN-1:0]    ex_rs1_data,
    output logic [XLEN-1:0]    ex_rs2_data,
    output logic [XLEN-1:0]    ex_imm,
    output logic [XLEN-1:0]    ex_pc,
    output logic               ex_alu_src,
    output logic [ALUOP_W-1:0] ex_alu_op,
    output logic               ex_mem_read,
    output logic               ex_mem_write,
    output logic               ex_reg_write,
    output logic               ex_mem_to_reg
`ifdef STALL_STATS_EN
    ,
    output logic [31:0]        stall_cnt
`endif
);

    typedef struct packed {
        logic               alu_src;
        logic [ALUOP_W-1:0] alu_op;
        logic               mem_read;
        logic               mem_write;
        logic               reg_write;
        logic               mem_to_reg;
    } ctrl_t;

    typedef struct packed {
        logic               valid;
        logic [REG_AW-1:0]  rs1;
        logic [REG_AW-1:0]  rs2;
        logic [REG_AW-1:0]  rd;
        logic [XLEN-1:0]    rs1_data;
        logic [XLEN-1:0]    rs2_data;
        logic [XLEN-1:0]    imm;
        logic [XLEN-1:0]    pc;
        ctrl_t              ctrl;
    } stage_t;

    typedef enum logic [2:0] {
        UPD_LOAD,
        UPD_HOLD,
        UPD_BUBBLE,
        UPD_FLUSH,
        UPD_RESET
    } upd_e;

    stage_t ex_q;
    stage_t ex_d;
    stage_t id_stage;
    ctrl_t  id_ctrl;
    upd_e   upd;

    logic   rd_nonzero;
    logic   rs1_match;
    logic   rs2_match;
    logic   hazard;

    // Load-use: the load sitting in EX writes a register the ID instruction reads.
    assign rd_nonzero = (ex_q.rd != '0);
    assign rs1_match  = (ex_q.rd == id_rs1);
    assign rs2_match  = id_uses_rs2 && (ex_q.rd == id_rs2);
    assign hazard     = id_valid && ex_q.valid && ex_q.ctrl.mem_read && rd_nonzero
                        && (rs1_match || rs2_match);

    assign stall_fd   = (hazard && !flush) || hold;

    always_comb begin
        upd = UPD_LOAD;
        if (reset) begin
            upd = UPD_RESET;
        end else if (flush) begin
            upd = UPD_FLUSH;
        end else if (hold) begin
            upd = UPD_HOLD;
        end else if (hazard) begin
            upd = UPD_BUBBLE;
        end
    end

    // Control is gated on id_valid so an empty slot can never write state downstream.
    always_comb begin
        id_ctrl = '0;
        if (id_valid) begin
            id_ctrl.alu_src    = id_alu_src;
            id_ctrl.alu_op     = id_alu_op;
            id_ctrl.mem_read   = id_mem_read;
            id_ctrl.mem_write  = id_mem_write;
            id_ctrl.reg_write  = id_reg_write;
            id_ctrl.mem_to_reg = id_mem_to_reg;
        end
    end

    always_comb begin
        id_stage          = '0;
        id_stage.valid    = id_valid;
        id_stage.rs1      = id_rs1;
        id_stage.rs2      = id_rs2;
        id_stage.rd       = id_rd;
        id_stage.rs1_data = id_rs1_data;
        id_stage.rs2_data = id_rs2_data;
        id_stage.imm      = id_imm;
        id_stage.pc       = id_pc;
        id_stage.ctrl     = id_ctrl;
    end

    always_comb begin
        ex_d = ex_q;
        case (upd)
            UPD_LOAD:   ex_d = id_stage;
            UPD_HOLD:   ex_d = ex_q;
            UPD_BUBBLE: ex_d = '0;
            UPD_FLUSH:  ex_d = '0;
            UPD_RESET:  ex_d = '0;
            default:    ex_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign ex_valid      = ex_q.valid;
    assign ex_rs1        = ex_q.rs1;
    assign ex_rs2        = ex_q.rs2;
    assign ex_rd         = ex_q.rd;
    assign ex_rs1_data   = ex_q.rs1_data;
    assign ex_rs2_data   = ex_q.rs2_data;
    assign ex_imm        = ex_q.imm;
    assign ex_pc         = ex_q.pc;
    assign ex_alu_src    = ex_q.ctrl.alu_src;
    assign ex_alu_op     = ex_q.ctrl.alu_op;
    assign ex_mem_read   = ex_q.ctrl.mem_read;
    assign ex_mem_write  = ex_q.ctrl.mem_write;
    assign ex_reg_write  = ex_q.ctrl.reg_write;
    assign ex_mem_to_reg = ex_q.ctrl.mem_to_reg;

`ifdef STALL_STATS_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;

    // Only real load-use bubbles count; held or flushed cycles are someone else's stall.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (upd == UPD_BUBBLE) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed table-driven bench for id_ex_stage_reg; counter checks are built when STALL_STATS_EN is defined.
module tb_id_ex_stage_reg;

    logic        clk;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_uses_rs2;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
    logic        id_alu_src;
    logic [3:0]  id_alu_op;
    logic        id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg;
    logic        flush, hold;
    logic        stall_fd;
    logic        ex_valid;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [31:0] ex_rs1_data, ex_rs2_data, ex_imm, ex_pc;
    logic        ex_alu_src;
    logic [3:0]  ex_alu_op;
    logic        ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg;
`ifdef STALL_STATS_EN
    logic [31:0] stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    id_ex_stage_reg dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
        .id_rd(id_rd), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_pc(id_pc), .id_alu_src(id_alu_src), .id_alu_op(id_alu_op),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg),
        .flush(flush), .hold(hold), .stall_fd(stall_fd),
        .ex_valid(ex_valid), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_pc(ex_pc),
        .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg)
`ifdef STALL_STATS_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst, v;
        logic [4:0]  rs1, rs2;
        logic        u2;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic        mr, rw, fl, hd, cs;
        logic        e_stall, e_v;
        logic [4:0]  e_rd, e_rs1;
        logic [31:0] e_pc, e_imm;
        logic        e_mr, e_rw;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic v, logic [4:0] rs1, logic [4:0] rs2, logic u2,
                                logic [4:0] rd, logic [31:0] pc, logic mr, logic rw,
                                logic fl, logic hd, logic cs, logic e_stall, logic e_v,
                                logic [4:0] e_rd, logic [4:0] e_rs1, logic [31:0] e_pc,
                                logic [31:0] e_imm, logic e_mr, logic e_rw);
        vec_t t;
        t.rst = rst; t.v = v; t.rs1 = rs1; t.rs2 = rs2; t.u2 = u2; t.rd = rd; t.pc = pc;
        t.mr = mr; t.rw = rw; t.fl = fl; t.hd = hd; t.cs = cs;
        t.e_stall = e_stall; t.e_v = e_v; t.e_rd = e_rd; t.e_rs1 = e_rs1;
        t.e_pc = e_pc; t.e_imm = e_imm; t.e_mr = e_mr; t.e_rw = e_rw;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u2, input logic [4:0] rd, input logic mr,
                          input logic rw, input logic fl);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs2 = u2; id_rd = rd;
        id_mem_read = mr; id_reg_write = rw; flush = fl; hold = 1'b0;
    endtask

    initial begin
        reset = 1'b1; id_valid = 1'b1; id_rs1 = 5'd3; id_rs2 = 5'd0; id_uses_rs2 = 1'b0;
        id_rd = 5'd9; id_rs1_data = 32'h0; id_rs2_data = 32'h0; id_imm = 32'h0; id_pc = 32'h0;
        id_alu_src = 1'b0; id_alu_op = 4'h0; id_mem_read = 1'b1; id_mem_write = 1'b0;
        id_reg_write = 1'b1; id_mem_to_reg = 1'b0; flush = 1'b0; hold = 1'b0;

        //               rst v rs1 rs2 u2 rd  pc     mr rw fl hd cs  st ev erd ers1 epc    eimm        emr erw
        vecs.push_back(mk(1,1, 3, 0, 0, 9, 32'h44, 1, 1, 0, 0, 0,  0, 0, 0, 0, 32'h0,  32'h0,      0, 0));
        vecs.push_back(mk(1,1, 5, 0, 0, 6, 32'h48, 0, 1, 0, 0, 1,  0, 0, 0, 0, 32'h0,  32'h0,      0, 0));
        vecs.push_back(mk(0,1, 1, 2, 1, 3, 32'h10, 0, 1, 0, 0, 1,  0, 1, 3, 1, 32'h10, 32'h1236,   0, 1));
        vecs.push_back(mk(0,1, 2, 0, 0, 5, 32'h14, 1, 1, 0, 0, 1,  0, 1, 5, 2, 32'h14, 32'h1237,   1, 1));
        vecs.push_back(mk(0,1, 5, 6, 1, 7, 32'h18, 0, 1, 0, 0, 1,  1, 0, 0, 0, 32'h0,  32'h0,      0, 0));
        vecs.push_back(mk(0,1, 5, 6, 1, 7, 32'h18, 0, 1, 0, 0, 1,  0, 1, 7, 5, 32'h18, 32'h1239,   0, 1));
        vecs.push_back(mk(0,1, 1, 0, 0, 0, 32'h1c, 1, 1, 0, 0, 1,  0, 1, 0, 1, 32'h1c, 32'h123a,   1, 1));
        vecs.push_back(mk(0,1, 0, 0, 1, 8, 32'h20, 0, 1, 0, 0, 1,  0, 1, 8, 0, 32'h20, 32'h123b,   0, 1));
        vecs.push_back(mk(0,1, 2, 0, 0, 7, 32'h24, 1, 1, 0, 0, 1,  0, 1, 7, 2, 32'h24, 32'h123c,   1, 1));
        vecs.push_back(mk(0,1, 3, 7, 0, 0, 32'h28, 0, 0, 0, 0, 1,  0, 1, 0, 3, 32'h28, 32'h123d,   0, 0));
        vecs.push_back(mk(0,1, 4, 0, 0, 9, 32'h2c, 1, 1, 0, 0, 1,  0, 1, 9, 4, 32'h2c, 32'h123e,   1, 1));
        vecs.push_back(mk(0,1, 1, 9, 1, 0, 32'h30, 0, 0, 0, 0, 1,  1, 0, 0, 0, 32'h0,  32'h0,      0, 0));
        vecs.push_back(mk(0,1, 1, 0, 0,11, 32'h34, 1, 1, 0, 0, 1,  0, 1,11, 1, 32'h34, 32'h1240,   1, 1));
        vecs.push_back(mk(0,1,11, 0, 0,12, 32'h38, 0, 1, 1, 0, 1,  0, 0, 0, 0, 32'h0,  32'h0,      0, 0));
        vecs.push_back(mk(0,1, 2, 0, 0,13, 32'h3c, 1, 1, 0, 0, 1,  0, 1,13, 2, 32'h3c, 32'h1242,   1, 1));
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(0,1,13,0,0,14,32'h40, 0, 1, 0, 1, 1,  1, 1,13, 2, 32'h3c, 32'h1242,   1, 1));
        vecs.push_back(mk(0,1,13, 0, 0,14, 32'h40, 0, 1, 0, 0, 1,  1, 0, 0, 0, 32'h0,  32'h0,      0, 0));
        vecs.push_back(mk(0,1,13, 0, 0,14, 32'h40, 0, 1, 0, 0, 1,  0, 1,14,13, 32'h40, 32'h1247,   0, 1));
        vecs.push_back(mk(0,0, 3, 0, 0,15, 32'h44, 1, 1, 0, 0, 1,  0, 0,15, 3, 32'h44, 32'h1248,   0, 0));
        vecs.push_back(mk(0,1, 1, 0, 0, 2, 32'h48, 0, 1, 0, 1, 1,  1, 0,15, 3, 32'h44, 32'h1248,   0, 0));
        vecs.push_back(mk(0,1, 1, 0, 0, 2, 32'h48, 0, 1, 1, 1, 1,  1, 0, 0, 0, 32'h0,  32'h0,      0, 0));
        vecs.push_back(mk(0,1, 1, 0, 0, 4, 32'h4c, 1, 1, 0, 0, 1,  0, 1, 4, 1, 32'h4c, 32'h124b,   1, 1));
        vecs.push_back(mk(1,1, 4, 0, 0, 5, 32'h50, 0, 1, 0, 0, 1,  1, 0, 0, 0, 32'h0,  32'h0,      0, 0));
        vecs.push_back(mk(0,1, 4, 0, 0, 5, 32'h50, 0, 1, 0, 0, 1,  0, 1, 5, 4, 32'h50, 32'h124d,   0, 1));

        foreach (vecs[i]) begin
            @(negedge clk);
            reset = vecs[i].rst; id_valid = vecs[i].v; id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2;
            id_uses_rs2 = vecs[i].u2; id_rd = vecs[i].rd; id_pc = vecs[i].pc;
            id_rs1_data = vecs[i].pc + 32'h100; id_rs2_data = vecs[i].pc + 32'h200;
            id_imm = 32'h1234 + 32'(i); id_mem_read = vecs[i].mr; id_reg_write = vecs[i].rw;
            id_mem_write = 1'b0; id_mem_to_reg = 1'b0; id_alu_src = 1'b0; id_alu_op = 4'h0;
            flush = vecs[i].fl; hold = vecs[i].hd;
            #1;
            if (vecs[i].cs) chk($sformatf("v%0d_stall_fd", i), 32'(stall_fd), 32'(vecs[i].e_stall));
            tick();
            chk($sformatf("v%0d_ex_valid", i), 32'(ex_valid), 32'(vecs[i].e_v));
            chk($sformatf("v%0d_ex_rd", i), 32'(ex_rd), 32'(vecs[i].e_rd));
            chk($sformatf("v%0d_ex_rs1", i), 32'(ex_rs1), 32'(vecs[i].e_rs1));
            chk($sformatf("v%0d_ex_pc", i), ex_pc, vecs[i].e_pc);
            chk($sformatf("v%0d_ex_imm", i), ex_imm, vecs[i].e_imm);
            chk($sformatf("v%0d_ex_mem_read", i), 32'(ex_mem_read), 32'(vecs[i].e_mr));
            chk($sformatf("v%0d_ex_reg_write", i), 32'(ex_reg_write), 32'(vecs[i].e_rw));
        end

        // Remaining control/data fields, then id_valid gating and flush clearing of them.
        @(negedge clk);
        set_id(1'b1, 5'd1, 5'd3, 1'b1, 5'd6, 1'b0, 1'b1, 1'b0);
        id_alu_src = 1'b1; id_alu_op = 4'hA; id_rs2_data = 32'hDEAD; id_mem_write = 1'b1;
        id_mem_to_reg = 1'b1;
        tick();
        chk("ld_alu_src", 32'(ex_alu_src), 32'd1);
        chk("ld_alu_op", 32'(ex_alu_op), 32'hA);
        chk("ld_rs2_data", ex_rs2_data, 32'hDEAD);
        chk("ld_rs2", 32'(ex_rs2), 32'd3);
        chk("ld_mem_write", 32'(ex_mem_write), 32'd1);
        chk("ld_mem_to_reg", 32'(ex_mem_to_reg), 32'd1);
        id_valid = 1'b0;
        tick();
        chk("gate_alu_op", 32'(ex_alu_op), 32'h0);
        chk("gate_mem_write", 32'(ex_mem_write), 32'd0);
        chk("gate_rs2_data", ex_rs2_data, 32'hDEAD);
        id_valid = 1'b1;
        tick();
        flush = 1'b1;
        tick();
        chk("fl_mem_to_reg", 32'(ex_mem_to_reg), 32'd0);
        chk("fl_mem_write", 32'(ex_mem_write), 32'd0);
        chk("fl_valid", 32'(ex_valid), 32'd0);
        id_alu_src = 1'b0; id_alu_op = 4'h0; id_mem_write = 1'b0; id_mem_to_reg = 1'b0;

`ifdef STALL_STATS_EN
        chk("cnt_start", stall_cnt, 32'd0);
        for (int k = 0; k < 4; k++) begin
            set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0);
            tick();
            set_id(1'b1, 5'd6, 5'd0, 1'b0, 5'd7, 1'b0, 1'b1, 1'b0);
            tick();
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0);
            tick();
            set_id(1'b1, 5'd6, 5'd0, 1'b0, 5'd7, 1'b0, 1'b1, 1'b1);
            tick();
        end
        chk("cnt_four", stall_cnt, 32'd4);
        set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0);
        force dut.stall_cnt_q = 32'hFFFF_FFFF;
        tick();
        release dut.stall_cnt_q;
        chk("cnt_forced", stall_cnt, 32'hFFFF_FFFF);
        set_id(1'b1, 5'd6, 5'd0, 1'b0, 5'd7, 1'b0, 1'b1, 1'b0);
        tick();
        chk("cnt_wrap", stall_cnt, 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("cnt_reset", stall_cnt, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
